// File: rtl/seq_chain_pkg.sv
// Shared types and constants for the sequential chain checker.
// The FSM state type and the MODE parameter encodings live here.
package seq_chain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MODE_ALL_ONES = 0;
    localparam int MODE_PATTERN  = 1;

endpackage : seq_chain_pkg

// File: rtl/seq_chain_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Reset outranks clear, and clear outranks increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/seq_chain_checker.sv
// Checks that vect[WIDTH-1] ##1 vect[WIDTH-2] ... ##1 vect[0] holds after each accepted trig.
// The outcome is reported one cycle after the deciding bit, and saturating statistics are kept.
module seq_chain_checker
    import seq_chain_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_ALL_ONES,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig,
    input  logic [WIDTH-1:0]         vect,
    input  logic [WIDTH-1:0]         exp_pat,
    input  logic                     clr_cnt,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(WIDTH)-1:0] fail_idx,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] FIRST_RUN = IDX_W'(WIDTH - 2);

    if (WIDTH < 2) begin : g_width_check
        $error("seq_chain_checker: WIDTH must be at least 2");
    end

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WIDTH-1:0]   pat_q, pat_n;
    logic [IDX_W-1:0]   fail_idx_n;
    logic               pass_n, fail_n, drop;

    // The first bit is judged in the accepting cycle, against the live exp_pat.
    logic               chk_en;
    logic [IDX_W-1:0]   cur_idx;
    logic [WIDTH-1:0]   ref_pat;
    logic [WIDTH-1:0]   bit_good;

    always_comb begin
        chk_en   = (state == RUN) || trig;
        cur_idx  = (state == RUN) ? idx : TOP_IDX;
        ref_pat  = (state == RUN) ? pat_q : exp_pat;
        bit_good = (MODE == MODE_PATTERN) ? ~(vect ^ ref_pat) : vect;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        pat_n      = pat_q;
        fail_idx_n = fail_idx;
        pass_n     = 1'b0;
        fail_n     = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    pat_n = exp_pat;
                    if (!bit_good[TOP_IDX]) begin
                        fail_n     = 1'b1;
                        fail_idx_n = TOP_IDX;
                    end else begin
                        state_n = RUN;
                        idx_n   = FIRST_RUN;
                    end
                end
            end
            RUN: begin
                drop = trig;
                if (!bit_good[idx]) begin
                    fail_n     = 1'b1;
                    fail_idx_n = idx;
                    state_n    = IDLE;
                end else if (idx == '0) begin
                    pass_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            pat_q    <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            fail_idx <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            pat_q    <= pat_n;
            pass     <= pass_n;
            fail     <= fail_n;
            fail_idx <= fail_idx_n;
        end
    end

    assign busy = (state == RUN);

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(pass_n), .count(pass_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(fail_n), .count(fail_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(drop), .count(drop_cnt)
    );

    // Each chain position either advances/passes or reports a fail at its own index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain_sva
        if (i == 0) begin : g_last
            a_bit_ok: assert property (@(posedge clk) disable iff (rst)
                (chk_en && cur_idx == IDX_W'(i) && bit_good[i]) |=> (pass && !busy));
        end else begin : g_mid
            a_bit_ok: assert property (@(posedge clk) disable iff (rst)
                (chk_en && cur_idx == IDX_W'(i) && bit_good[i]) |=> (busy && idx == IDX_W'(i - 1)));
        end
        a_bit_bad: assert property (@(posedge clk) disable iff (rst)
            (chk_en && cur_idx == IDX_W'(i) && !bit_good[i])
            |=> (fail && fail_idx == IDX_W'(i) && !busy));
    end

    a_pass_fail_excl: assert property (@(posedge clk) disable iff (rst) !(pass && fail));

endmodule : seq_chain_checker

// File: tb/tb_seq_chain_checker.sv
// Scoreboard bench: three configurations (ALL_ONES, PATTERN, 2-bit counters) share stimulus;
// each scenario selects the instance under test and compares its outputs against a reference model.
module tb_seq_chain_checker;

    typedef struct {
        logic       is_pass;
        logic [1:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, trig, clr_cnt;
    logic [3:0]  vect, exp_pat;

    logic        busy0, pass0, fail0, busy1, pass1, fail1, busy2, pass2, fail2;
    logic [1:0]  fidx0, fidx1, fidx2;
    logic [15:0] pc0, fc0, dc0, pc1, fc1, dc1;
    logic [1:0]  pc2, fc2, dc2;

    logic        o_busy, o_pass, o_fail;
    logic [1:0]  o_fidx;
    logic [15:0] o_pc, o_fc, o_dc;

    int   sel = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seq_chain_checker #(.WIDTH(4), .MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .trig(trig), .vect(vect), .exp_pat(exp_pat), .clr_cnt(clr_cnt),
        .busy(busy0), .pass(pass0), .fail(fail0), .fail_idx(fidx0),
        .pass_cnt(pc0), .fail_cnt(fc0), .drop_cnt(dc0)
    );
    seq_chain_checker #(.WIDTH(4), .MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .trig(trig), .vect(vect), .exp_pat(exp_pat), .clr_cnt(clr_cnt),
        .busy(busy1), .pass(pass1), .fail(fail1), .fail_idx(fidx1),
        .pass_cnt(pc1), .fail_cnt(fc1), .drop_cnt(dc1)
    );
    seq_chain_checker #(.WIDTH(4), .MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .trig(trig), .vect(vect), .exp_pat(exp_pat), .clr_cnt(clr_cnt),
        .busy(busy2), .pass(pass2), .fail(fail2), .fail_idx(fidx2),
        .pass_cnt(pc2), .fail_cnt(fc2), .drop_cnt(dc2)
    );

    always_comb begin
        o_busy = busy0; o_pass = pass0; o_fail = fail0; o_fidx = fidx0;
        o_pc = pc0; o_fc = fc0; o_dc = dc0;
        case (sel)
            1: begin
                o_busy = busy1; o_pass = pass1; o_fail = fail1; o_fidx = fidx1;
                o_pc = pc1; o_fc = fc1; o_dc = dc1;
            end
            2: begin
                o_busy = busy2; o_pass = pass2; o_fail = fail2; o_fidx = fidx2;
                o_pc = {14'd0, pc2}; o_fc = {14'd0, fc2}; o_dc = {14'd0, dc2};
            end
            default: ;
        endcase
    end

    // Scoreboard: every pass/fail pulse must match the oldest predicted outcome.
    always @(negedge clk) begin
        if (!rst && (o_pass === 1'b1 || o_fail === 1'b1)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got pass=%b fail=%b idx=%0d, expected no pulse",
                         o_pass, o_fail, o_fidx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_pass !== e.is_pass || o_fail !== !e.is_pass ||
                    (!e.is_pass && o_fidx !== e.idx)) begin
                    bad++;
                    $display("FAIL outcome: got pass=%b fail=%b idx=%0d, expected pass=%b idx=%0d",
                             o_pass, o_fail, o_fidx, e.is_pass, e.idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; trig = 1'b0; clr_cnt = 1'b0; vect = '0; exp_pat = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Drives one attempt starting in the current cycle; bits[3-k] is streamed at cycle k.
    // Returns in the cycle where the outcome pulse should be visible.
    task automatic run_attempt(input int mode, input logic [3:0] pat, input logic [3:0] bits,
                               input int drop_at, input int clr_at);
        logic [3:0] v;
        logic       ok;
        exp_t       e;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            v        = 4'($urandom);
            v[3-k]   = bits[3-k];
            vect     = v;
            trig     = (k == 0) || (k == drop_at);
            clr_cnt  = (k == clr_at);
            exp_pat  = (k == 0) ? pat : 4'($urandom);
            total++;
            if (o_busy !== 1'(k > 0)) begin
                bad++;
                $display("FAIL busy_cycle%0d: got %b, expected %b", k, o_busy, 1'(k > 0));
            end
            ok = (mode == 1) ? (bits[3-k] == pat[3-k]) : bits[3-k];
            if (!ok) begin
                e.is_pass = 1'b0;
                e.idx     = 2'(3 - k);
                exp_q.push_back(e);
                break;
            end
            if (k == 3) begin
                e.is_pass = 1'b1;
                e.idx     = '0;
                exp_q.push_back(e);
            end
        end
        step();
        trig = 1'b0; vect = '0; clr_cnt = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    task automatic expect_val(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            expect_val("reset_busy", 16'(o_busy), 16'd0);
            expect_val("reset_pulses", 16'({o_pass, o_fail}), 16'd0);
            expect_val("reset_fail_idx", 16'(o_fidx), 16'd0);
            expect_val("reset_counters", o_pc | o_fc | o_dc, 16'd0);
        end
        sel = 0;
    endtask

    task automatic test_all_ones();
        sel = 0;
        apply_reset();
        run_attempt(0, 4'h0, 4'b1111, -1, -1);
        expect_val("ones_pass_pulse", 16'(o_pass), 16'd1);
        expect_val("ones_pass_cnt", o_pc, 16'd1);
        expect_val("ones_busy_after", 16'(o_busy), 16'd0);
        wait_drain();
    endtask

    task automatic test_fail();
        sel = 0;
        apply_reset();
        run_attempt(0, 4'h0, 4'b1101, -1, -1);
        expect_val("mid_fail_pulse", 16'(o_fail), 16'd1);
        expect_val("mid_fail_idx", 16'(o_fidx), 16'd1);
        expect_val("mid_fail_cnt", o_fc, 16'd1);
        expect_val("mid_fail_busy", 16'(o_busy), 16'd0);
        wait_drain();
        run_attempt(0, 4'h0, 4'b0111, -1, -1);
        expect_val("idle_fail_idx", 16'(o_fidx), 16'd3);
        expect_val("idle_fail_busy", 16'(o_busy), 16'd0);
        expect_val("idle_fail_cnt", o_fc, 16'd2);
        wait_drain();
        repeat (3) step();
        expect_val("fail_idx_held", 16'(o_fidx), 16'd3);
        run_attempt(0, 4'h0, 4'b1111, -1, -1);
        expect_val("fail_idx_held_pass", 16'(o_fidx), 16'd3);
        wait_drain();
    endtask

    task automatic test_pattern();
        logic [3:0] pat, bits;
        sel = 1;
        apply_reset();
        run_attempt(1, 4'b1010, 4'b1010, -1, -1);
        expect_val("pat_pass_pulse", 16'(o_pass), 16'd1);
        wait_drain();
        run_attempt(1, 4'b1010, 4'b1100, -1, -1);
        expect_val("pat_fail_pulse", 16'(o_fail), 16'd1);
        expect_val("pat_fail_idx", 16'(o_fidx), 16'd2);
        wait_drain();
        for (int n = 0; n < 8; n++) begin
            pat  = 4'($urandom);
            bits = ($urandom_range(0, 2) == 0) ? pat : pat ^ (4'b0001 << $urandom_range(0, 3));
            run_attempt(1, pat, bits, -1, -1);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        sel = 0;
        apply_reset();
        run_attempt(0, 4'h0, 4'b1111, 2, -1);
        expect_val("b2b_first_pass", 16'(o_pass), 16'd1);
        expect_val("b2b_drop_cnt", o_dc, 16'd1);
        run_attempt(0, 4'h0, 4'b1111, -1, -1);
        expect_val("b2b_second_pass", 16'(o_pass), 16'd1);
        expect_val("b2b_pass_cnt", o_pc, 16'd2);
        wait_drain();
    endtask

    task automatic test_saturate();
        sel = 2;
        apply_reset();
        for (int n = 1; n <= 5; n++) begin
            run_attempt(0, 4'h0, 4'b1111, -1, -1);
            expect_val($sformatf("sat_pass_cnt_%0d", n), o_pc, 16'((n > 3) ? 3 : n));
        end
        run_attempt(0, 4'h0, 4'b1111, -1, 3);
        expect_val("clr_beats_inc", o_pc, 16'd0);
        run_attempt(0, 4'h0, 4'b1111, -1, -1);
        expect_val("sat_after_clr", o_pc, 16'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        expect_val("clr_with_pulse", o_pc, 16'd0);
        wait_drain();
    endtask

    task automatic test_reset_run();
        sel = 0;
        apply_reset();
        run_attempt(0, 4'h0, 4'b1111, -1, -1);
        run_attempt(0, 4'h0, 4'b1011, -1, -1);
        wait_drain();
        trig = 1'b1; vect = 4'hF;
        step();
        trig = 1'b1;
        step();
        trig = 1'b1; rst = 1'b1;
        expect_val("pre_rst_drop", o_dc, 16'd1);
        expect_val("pre_rst_busy", 16'(o_busy), 16'd1);
        step();
        rst = 1'b0; trig = 1'b0; vect = '0;
        expect_val("rst_run_busy", 16'(o_busy), 16'd0);
        expect_val("rst_run_pulses", 16'({o_pass, o_fail}), 16'd0);
        expect_val("rst_run_counters", o_pc | o_fc | o_dc, 16'd0);
        repeat (6) step();
        expect_val("rst_run_quiet", o_pc | o_fc, 16'd0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_fail();
        test_pattern();
        test_back_to_back();
        test_saturate();
        test_reset_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_chain_checker
